// File: rtl/generador_frecuencia_pkg.sv
// Shared constants for the frequency generator slice.
//   CLK_FREQ_DEF : default system clock frequency in Hz
//   WIDTH_DEF    : default frequency/period datapath width (matches freq_out[27:0])
//   gen_state_t  : request FSM states
package generador_frecuencia_pkg;

    localparam int unsigned CLK_FREQ_DEF = 100_000_000;
    localparam int unsigned WIDTH_DEF    = 28;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIVIDE,
        LOAD,
        RUN
    } gen_state_t;

endpackage

// File: rtl/generador_frecuencia_if.sv
// Frequency request handshake.
//   freq_req   : requested frequency in Hz
//   freq_valid : freq_req is valid
//   freq_ready : generator can accept a request
// master = requester side, slave = generator side.
interface generador_frecuencia_if #(
    parameter int unsigned WIDTH = 28
) ();

    logic [WIDTH-1:0] freq_req;
    logic             freq_valid;
    logic             freq_ready;

    modport master (output freq_req, output freq_valid, input  freq_ready);
    modport slave  (input  freq_req, input  freq_valid, output freq_ready);

endinterface

// File: rtl/generador_frecuencia_divisor_secuencial.sv
// Sequential restoring divider, one quotient bit per cycle, WIDTH cycles total.
// The first step is taken on the start cycle itself, straight from the input
// operands, so the quotient is valid (and done pulses) WIDTH cycles after start.
//   clk, rst  : clock, asynchronous active-low reset
//   start     : begin a division (operands sampled this cycle)
//   dividend  : WIDTH-bit dividend
//   divisor   : WIDTH+1-bit divisor (non-zero)
//   busy      : division in progress
//   done      : one-cycle pulse, quotient valid
//   quotient  : floor(dividend / divisor)
module divisor_secuencial #(
    parameter int unsigned WIDTH = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH:0]   divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH:0]   div_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   rem_in;
    logic [WIDTH-1:0] dvd_in;
    logic [WIDTH:0]   div_in;
    logic [WIDTH+1:0] trial;
    logic [WIDTH+1:0] diff;
    logic             ge;
    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] dvd_nx;

    // Dividend register shifts out its MSB into the remainder and shifts
    // the quotient bit in at the LSB, so it ends up holding the quotient.
    always_comb begin
        rem_in = start ? '0 : rem_q;
        dvd_in = start ? dividend : dvd_q;
        div_in = start ? divisor : div_q;
        trial  = {rem_in, dvd_in[WIDTH-1]};
        diff   = trial - {1'b0, div_in};
        ge     = (trial >= {1'b0, div_in});
        rem_nx = ge ? diff[WIDTH:0] : trial[WIDTH:0];
        dvd_nx = {dvd_in[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q <= '0;
            dvd_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q <= rem_nx;
                dvd_q <= dvd_nx;
                div_q <= div_in;
                cnt_q <= CNT_W'(1);
                busy  <= 1'b1;
            end else if (busy) begin
                rem_q <= rem_nx;
                dvd_q <= dvd_nx;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign quotient = dvd_q;

endmodule

// File: rtl/generador_frecuencia.sv
// Programmable 50% duty square-wave source.
// A requested frequency f is accepted over the handshake, range-checked,
// and half_period = floor(CLK_FREQ / (2*f)) is computed by a sequential
// divider; signal_out toggles every half_period enabled clock cycles.
//   clk         : system clock
//   rst         : asynchronous active-low reset
//   enable      : 1 = generate, 0 = freeze counter and output level
//   req_if      : frequency request handshake (slave)
//   signal_out  : generated square wave
//   active      : a valid period is loaded and generation is running
//   freq_err    : last request was out of range
//   half_period : loaded half period in clk cycles
module generador_frecuencia
    import generador_frecuencia_pkg::*;
#(
    parameter int unsigned CLK_FREQ = CLK_FREQ_DEF,
    parameter int unsigned WIDTH    = WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    generador_frecuencia_if.slave req_if,
    output logic                  signal_out,
    output logic                  active,
    output logic                  freq_err,
    output logic [WIDTH-1:0]      half_period
);

    localparam logic [WIDTH-1:0] F_MAX    = WIDTH'(CLK_FREQ / 2);
    localparam logic [WIDTH-1:0] DIVIDEND = WIDTH'(CLK_FREQ);

    gen_state_t       state, state_nx;
    logic [WIDTH-1:0] req_q;
    logic [WIDTH-1:0] counter;

    logic             freq_ready;
    logic             accept;
    logic             in_range;
    logic             start_div;
    logic             do_load;
    logic             set_err;
    logic             clr_err;

    logic             div_busy;
    logic             div_done;
    logic [WIDTH-1:0] quotient;

    divisor_secuencial #(.WIDTH(WIDTH)) u_divisor (
        .clk      (clk),
        .rst      (rst),
        .start    (start_div),
        .dividend (DIVIDEND),
        .divisor  ({req_q, 1'b0}),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );

    assign in_range          = (req_q != '0) && (req_q <= F_MAX);
    assign req_if.freq_ready = freq_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        start_div  = 1'b0;
        do_load    = 1'b0;
        set_err    = 1'b0;
        clr_err    = 1'b0;
        freq_ready = ((state == IDLE) || (state == RUN)) && !div_busy;
        accept     = req_if.freq_valid && freq_ready;
        case (state)
            IDLE:   if (accept) state_nx = CHECK;
            CHECK: begin
                if (!in_range) begin
                    set_err  = 1'b1;
                    state_nx = active ? RUN : IDLE;
                end else begin
                    clr_err   = 1'b1;
                    start_div = 1'b1;
                    state_nx  = DIVIDE;
                end
            end
            DIVIDE: if (div_done) state_nx = LOAD;
            LOAD: begin
                do_load  = 1'b1;
                state_nx = RUN;
            end
            RUN:    if (accept) state_nx = CHECK;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q       <= '0;
            freq_err    <= 1'b0;
            active      <= 1'b0;
            half_period <= '0;
        end else begin
            if (accept)  req_q    <= req_if.freq_req;
            if (set_err) freq_err <= 1'b1;
            if (clr_err) freq_err <= 1'b0;
            if (do_load) begin
                half_period <= quotient;
                active      <= 1'b1;
            end
        end
    end

    // '>=' rather than '==' so a retune to a shorter period toggles at once
    // instead of counting up through the full counter range.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter    <= '0;
            signal_out <= 1'b0;
        end else if (do_load && !active) begin
            counter    <= '0;
            signal_out <= 1'b0;
        end else if (active && enable) begin
            if (counter >= half_period - WIDTH'(1)) begin
                counter    <= '0;
                signal_out <= ~signal_out;
            end else begin
                counter <= counter + WIDTH'(1);
            end
        end
    end

endmodule
